pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with valid/ready handshake,
// flush squash of held control bits and a saturating back-pressure counter.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 3,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [CTRL_W-1:0]   main_ctrl_reg;
    logic [DATA_W-1:0]   main_data_reg;
    logic [CTRL_W-1:0]   skid_ctrl_reg;
    logic [DATA_W-1:0]   skid_data_reg;
    logic [STALL_W-1:0]  stall_cnt_reg;
    logic                accept;
    logic                take;

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush overrides any handshake in the same cycle
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: if (accept) state_next = ONE;
                ONE: begin
                    if (accept && !take)      state_next = TWO;
                    else if (!accept && take) state_next = EMPTY;
                end
                TWO: if (take) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Outputs depend only on registered state (in_ready has no path from out_ready)
    always_comb begin
        in_ready  = (state_reg != TWO) && !rst;
        out_valid = (state_reg != EMPTY);
        out_ctrl  = out_valid ? main_ctrl_reg : '0;
        out_data  = main_data_reg;
        stall_cnt = stall_cnt_reg;
    end

    // Entry storage: MAIN is presented, SKID catches the overflow entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else if (flush) begin
            main_ctrl_reg <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl_reg <= in_ctrl;
                        main_data_reg <= in_data;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_ctrl_reg <= in_ctrl;
                        main_data_reg <= in_data;
                    end else if (accept) begin
                        skid_ctrl_reg <= in_ctrl;
                        skid_data_reg <= in_data;
                    end
                end
                TWO: begin
                    if (take) begin
                        main_ctrl_reg <= skid_ctrl_reg;
                        main_data_reg <= skid_data_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Back-pressure counter saturates and ignores flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != {STALL_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed streaming, back-pressure,
// flush, reset and saturation vectors followed by a random valid/ready run.
module tb_pipe_stage_reg;

    localparam int DW = 64;
    localparam int CW = 3;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [SW-1:0] stall_cnt;

    logic          sat_flush;
    logic          sat_in_valid;
    logic          sat_in_ready;
    logic [1:0]    sat_in_ctrl;
    logic [7:0]    sat_in_data;
    logic          sat_out_valid;
    logic          sat_out_ready;
    logic [1:0]    sat_out_ctrl;
    logic [7:0]    sat_out_data;
    logic [3:0]    sat_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW+DW-1:0] exp_q[$];
    logic [SW-1:0]    stall_exp;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_W(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(2), .STALL_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(sat_flush),
        .in_valid(sat_in_valid), .in_ready(sat_in_ready), .in_ctrl(sat_in_ctrl),
        .in_data(sat_in_data), .out_valid(sat_out_valid), .out_ready(sat_out_ready),
        .out_ctrl(sat_out_ctrl), .out_data(sat_out_data), .stall_cnt(sat_stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT outputs with the scoreboard, then advances the model
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        logic [CW+DW-1:0] head;
        if (rst) begin
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
            check("rst_out_data", out_data, 64'd0);
            check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
            exp_q.delete();
            stall_exp = '0;
        end else begin
            exp_valid = (exp_q.size() > 0);
            exp_ready = (exp_q.size() < 2);
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
            if (exp_valid) begin
                head = exp_q[0];
                check("out_ctrl", 64'(out_ctrl), 64'(head[CW+DW-1:DW]));
                check("out_data", out_data, head[DW-1:0]);
            end else begin
                check("bubble_ctrl", 64'(out_ctrl), 64'd0);
            end
            if (exp_valid && !out_ready && stall_exp != {SW{1'b1}})
                stall_exp = stall_exp + 1'b1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_valid && out_ready) void'(exp_q.pop_front());
                if (in_valid && exp_ready) exp_q.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        logic [SW-1:0] stall_base;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        sat_flush = 1'b0; sat_in_valid = 1'b0; sat_in_ctrl = '0; sat_in_data = '0; sat_out_ready = 1'b0;
        #1;
        check("t0_out_valid", 64'(out_valid), 64'd0);
        check("t0_in_ready", 64'(in_ready), 64'd0);
        check("t0_stall", 64'(stall_cnt), 64'd0);
        tick(); tick();
        rst = 1'b0;
        #0;
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Streaming 0x1..0x8 with ctrl 101
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = 3'b101; in_data = 64'(i);
            tick();
            check("stream_data", out_data, 64'(i));
            check("stream_ctrl", 64'(out_ctrl), 64'b101);
        end
        in_valid = 1'b0;
        tick(); tick();
        check("stream_stall", 64'(stall_cnt), 64'd0);

        // Back-pressure: A then B held, then drained
        stall_base = stall_cnt;
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 3'b011; in_data = 64'hA; tick();
        in_data = 64'hB; tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_data", out_data, 64'hA);
        check("bp_stall", 64'(stall_cnt), 64'(stall_base + 16'd4));
        out_ready = 1'b1;
        tick();
        check("bp_second", out_data, 64'hB);
        tick(); tick();

        // Flush in TWO while offering 0xC
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 3'b111; in_data = 64'h1; tick();
        in_data = 64'h2; tick();
        flush = 1'b1; in_data = 64'hC; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick(); tick();

        // Asynchronous reset in TWO
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 3'b110; in_data = 64'h55; tick();
        in_data = 64'h66; tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ctrl", 64'(out_ctrl), 64'd0);
        check("arst_data", out_data, 64'd0);
        check("arst_stall", 64'(stall_cnt), 64'd0);
        tick();
        rst = 1'b0;
        #0;
        check("arst_release_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 3'b001; in_data = 64'hD; tick();
        in_valid = 1'b0;
        check("arst_first_valid", 64'(out_valid), 64'd1);
        check("arst_first_data", out_data, 64'hD);
        tick(); tick();

        // Saturation on the 4-bit counter instance
        sat_in_valid = 1'b1; sat_in_data = 8'h5A; sat_in_ctrl = 2'b10; tick();
        sat_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_valid", 64'(sat_out_valid), 64'd1);
        check("sat_cnt", 64'(sat_stall_cnt), 64'd15);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", 64'(sat_stall_cnt), 64'd15);

        // Random valid/ready/flush traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 63) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom};
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
